// File: rtl/rgmii_tx_pkg.sv
// Shared encodings for the tri-speed RGMII transmit framer/rate adapter.
package rgmii_tx_pkg;

    localparam logic [1:0] SPD_10   = 2'b00;
    localparam logic [1:0] SPD_100  = 2'b01;
    localparam logic [1:0] SPD_1000 = 2'b10;

    localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0] SFD_BYTE      = 8'hD5;
    localparam int         PREAMBLE_LEN  = 7;

    typedef enum logic [1:0] {
        IDLE,
        PREAMBLE,
        DATA,
        IFG
    } tx_state_t;

    // 2'b11 is an alias for 10 Mb/s; fold it so a 00<->11 swap is not a change.
    function automatic logic [1:0] spd_norm(input logic [1:0] s);
        return (s == SPD_1000 || s == SPD_100) ? s : SPD_10;
    endfunction

endpackage

// File: rtl/rgmii_tx_clk_gen.sv
// Nibble/slot timing and registered TXC half-cycle values for 10/100/1000.
module rgmii_tx_clk_gen
    import rgmii_tx_pkg::*;
#(
    parameter int DIV_100 = 5,
    parameter int DIV_10  = 50
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] speed_q,
    input  logic [1:0] speed_nx,
    input  logic       clr,
    output logic       ddr_clk1,
    output logic       ddr_clk2,
    output logic       hi,
    output logic       nib_end,
    output logic       slot_end,
    output logic       slot_end_nx
);

    localparam int DMAX = (DIV_10 > DIV_100) ? DIV_10 : DIV_100;
    localparam int CW   = (DMAX > 1) ? $clog2(DMAX) : 1;
    localparam int CW1  = CW + 1;
    localparam logic [CW:0] N100 = CW1'(DIV_100);
    localparam logic [CW:0] N10  = CW1'(DIV_10);

    logic [CW-1:0] cyc;
    logic [CW-1:0] cyc_d;
    logic          hi_d;
    logic [CW:0]   lim;
    logic [CW:0]   lim_nx;
    logic [CW:0]   two_c;
    logic          clk1_d;
    logic          clk2_d;

    function automatic logic [CW:0] nib_len(input logic [1:0] s);
        return (s == SPD_100) ? N100 : N10;
    endfunction

    always_comb begin
        lim     = nib_len(speed_q);
        lim_nx  = nib_len(speed_nx);
        nib_end  = (speed_q == SPD_1000) || ({1'b0, cyc} == lim - 1'b1);
        slot_end = (speed_q == SPD_1000) || (nib_end && hi);

        cyc_d = cyc + 1'b1;
        hi_d  = hi;
        if (clr || speed_q == SPD_1000) begin
            cyc_d = '0;
            hi_d  = 1'b0;
        end else if (nib_end) begin
            cyc_d = '0;
            hi_d  = ~hi;
        end

        // TXC and slot-end are produced for the position the counter moves to,
        // so the registered copies line up with the cycle they describe.
        slot_end_nx = (speed_nx == SPD_1000) ||
                      (({1'b0, cyc_d} == lim_nx - 1'b1) && hi_d);
        two_c  = {cyc_d, 1'b0};
        clk1_d = (speed_nx == SPD_1000) || (two_c < lim_nx);
        clk2_d = (speed_nx != SPD_1000) && ((two_c + 1'b1) < lim_nx);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cyc      <= '0;
            hi       <= 1'b0;
            ddr_clk1 <= 1'b0;
            ddr_clk2 <= 1'b0;
        end else begin
            cyc      <= cyc_d;
            hi       <= hi_d;
            ddr_clk1 <= clk1_d;
            ddr_clk2 <= clk2_d;
        end
    end

endmodule

// File: rtl/rgmii_tx_rate_adapter.sv
// RGMII transmit framer: preamble/SFD insertion, IFG, underrun handling and
// per-speed DDR bit-pair generation feeding the ODDR pad cells.
module rgmii_tx_rate_adapter
    import rgmii_tx_pkg::*;
#(
    parameter int DIV_100   = 5,
    parameter int DIV_10    = 50,
    parameter int IFG_BYTES = 12
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] speed,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    input  logic       s_last,
    input  logic       s_err,
    output logic       s_ready,
    output logic [3:0] ddr_d1,
    output logic [3:0] ddr_d2,
    output logic       ddr_ctl1,
    output logic       ddr_ctl2,
    output logic       ddr_clk1,
    output logic       ddr_clk2,
    output logic       busy,
    output logic       underrun
);

    localparam int IW = $clog2(IFG_BYTES + 1);

    tx_state_t     state, state_d;
    logic [1:0]    speed_q, speed_d, spd_in;
    logic [2:0]    pre_cnt, pre_d;
    logic [IW-1:0] ifg_cnt, ifg_d;
    logic [7:0]    data_q, data_d;
    logic          err_q, err_d;
    logic          ended_q, ended_d;
    logic          ur_q, ur_d;

    logic          clr, acc, starve;
    logic          hi, nib_end, slot_end, slot_end_nx;
    logic          nib_sel;
    logic [7:0]    tx_byte;
    logic          tx_en, tx_er;
    logic [3:0]    txd1_d, txd2_d;
    logic          ready_d;

    rgmii_tx_clk_gen #(
        .DIV_100 (DIV_100),
        .DIV_10  (DIV_10)
    ) u_clk_gen (
        .clk         (clk),
        .rst         (rst),
        .speed_q     (speed_q),
        .speed_nx    (speed_d),
        .clr         (clr),
        .ddr_clk1    (ddr_clk1),
        .ddr_clk2    (ddr_clk2),
        .hi          (hi),
        .nib_end     (nib_end),
        .slot_end    (slot_end),
        .slot_end_nx (slot_end_nx)
    );

    always_comb begin
        spd_in  = spd_norm(speed);
        clr     = (state == IDLE) && (spd_in != speed_q);
        speed_d = clr ? spd_in : speed_q;
        acc     = s_ready && s_valid;
        starve  = s_ready && !s_valid;

        state_d = state;
        pre_d   = pre_cnt;
        ifg_d   = ifg_cnt;
        data_d  = acc ? s_data : data_q;
        err_d   = acc ? s_err : err_q;
        ended_d = acc ? s_last : ended_q;
        ur_d    = ur_q;

        case (state)
            IDLE: begin
                if (!clr && s_valid && slot_end) begin
                    state_d = PREAMBLE;
                    pre_d   = '0;
                    ended_d = 1'b0;
                    ur_d    = 1'b0;
                end
            end
            PREAMBLE: begin
                if (slot_end) begin
                    if (pre_cnt == 3'(PREAMBLE_LEN)) begin
                        state_d = DATA;
                        ur_d    = starve;
                    end else begin
                        pre_d = pre_cnt + 3'd1;
                    end
                end
            end
            DATA: begin
                if (slot_end) begin
                    if (ur_q || ended_q) begin
                        state_d = IFG;
                        ifg_d   = '0;
                    end else begin
                        ur_d = starve;
                    end
                end
            end
            IFG: begin
                if (slot_end) begin
                    if (ifg_cnt == IW'(IFG_BYTES - 1)) begin
                        state_d = IDLE;
                    end else begin
                        ifg_d = ifg_cnt + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        tx_byte = 8'h00;
        tx_en   = 1'b0;
        tx_er   = 1'b0;
        case (state_d)
            PREAMBLE: begin
                tx_en   = 1'b1;
                tx_byte = (pre_d == 3'(PREAMBLE_LEN)) ? SFD_BYTE : PREAMBLE_BYTE;
            end
            DATA: begin
                tx_en = 1'b1;
                if (ur_d) begin
                    tx_er = 1'b1;
                end else begin
                    tx_byte = data_d;
                    tx_er   = err_d;
                end
            end
            default: ;
        endcase

        // Nibble select for the next cycle mirrors the generator's hi update.
        nib_sel = clr ? 1'b0 : (nib_end ? ~hi : hi);
        if (speed_d == SPD_1000) begin
            txd1_d = tx_byte[3:0];
            txd2_d = tx_byte[7:4];
        end else begin
            txd1_d = nib_sel ? tx_byte[7:4] : tx_byte[3:0];
            txd2_d = txd1_d;
        end

        ready_d = slot_end_nx &&
                  ((state_d == PREAMBLE && pre_d == 3'(PREAMBLE_LEN)) ||
                   (state_d == DATA && !ur_d && !ended_d));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            speed_q  <= spd_in;
            pre_cnt  <= '0;
            ifg_cnt  <= '0;
            data_q   <= '0;
            err_q    <= 1'b0;
            ended_q  <= 1'b0;
            ur_q     <= 1'b0;
            s_ready  <= 1'b0;
            ddr_d1   <= '0;
            ddr_d2   <= '0;
            ddr_ctl1 <= 1'b0;
            ddr_ctl2 <= 1'b0;
            busy     <= 1'b0;
            underrun <= 1'b0;
        end else begin
            state    <= state_d;
            speed_q  <= speed_d;
            pre_cnt  <= pre_d;
            ifg_cnt  <= ifg_d;
            data_q   <= data_d;
            err_q    <= err_d;
            ended_q  <= ended_d;
            ur_q     <= ur_d;
            s_ready  <= ready_d;
            ddr_d1   <= txd1_d;
            ddr_d2   <= txd2_d;
            ddr_ctl1 <= tx_en;
            ddr_ctl2 <= tx_en ^ tx_er;
            busy     <= (state_d != IDLE);
            underrun <= starve;
        end
    end

endmodule

// File: tb/tb_rgmii_tx_rate_adapter.sv
// Directed bench for rgmii_tx_rate_adapter: framing, 10/100 TXC shape,
// underrun, TX_ER, frozen speed and mid-frame reset.
module tb_rgmii_tx_rate_adapter;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] speed;
    logic [7:0] s_data;
    logic       s_valid, s_last, s_err;
    logic       s_ready;
    logic [3:0] ddr_d1, ddr_d2;
    logic       ddr_ctl1, ddr_ctl2, ddr_clk1, ddr_clk2, busy, underrun;

    always #4 clk = ~clk;

    rgmii_tx_rate_adapter #(
        .DIV_100   (5),
        .DIV_10    (50),
        .IFG_BYTES (12)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .speed    (speed),
        .s_data   (s_data),
        .s_valid  (s_valid),
        .s_last   (s_last),
        .s_err    (s_err),
        .s_ready  (s_ready),
        .ddr_d1   (ddr_d1),
        .ddr_d2   (ddr_d2),
        .ddr_ctl1 (ddr_ctl1),
        .ddr_ctl2 (ddr_ctl2),
        .ddr_clk1 (ddr_clk1),
        .ddr_clk2 (ddr_clk2),
        .busy     (busy),
        .underrun (underrun)
    );

    typedef struct packed {
        logic [3:0] d1;
        logic [3:0] d2;
        logic       c1;
        logic       c2;
        logic       k1;
        logic       k2;
        logic       rdy;
        logic       bsy;
        logic       ur;
    } smp_t;

    smp_t       rec [0:255];
    logic [7:0] q_data [0:7];
    logic       q_err  [0:7];
    int         q_len, q_idx, q_drop;
    int         n_assert = 0;
    int         n_fail   = 0;
    int         steps, cnt, edge_at;
    logic [3:0] n;
    logic [1:0] clk100 [0:4];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [9:0] pk(input logic [3:0] a, input logic [3:0] b,
                                      input logic c, input logic d);
        return {a, b, c, d};
    endfunction

    function automatic logic [9:0] pat(input int i);
        return {rec[i].d1, rec[i].d2, rec[i].c1, rec[i].c2};
    endfunction

    task automatic load();
        if (q_idx < q_len && q_idx != q_drop) begin
            s_valid = 1'b1;
            s_data  = q_data[q_idx];
            s_err   = q_err[q_idx];
            s_last  = (q_idx == q_len - 1);
        end else begin
            s_valid = 1'b0;
            s_data  = 8'h00;
            s_err   = 1'b0;
            s_last  = 1'b0;
        end
    endtask

    task automatic step();
        logic hs;
        hs = (s_valid === 1'b1) && (s_ready === 1'b1);
        @(posedge clk);
        #1;
        if (hs) begin
            q_idx++;
            load();
        end
    endtask

    task automatic idle(input int k);
        repeat (k) step();
    endtask

    task automatic start_frame(input int len);
        q_len = len;
        q_idx = 0;
        load();
    endtask

    task automatic cap(input int k);
        for (int i = 0; i < k; i++) begin
            if (i > 0) step();
            rec[i] = {ddr_d1, ddr_d2, ddr_ctl1, ddr_ctl2, ddr_clk1, ddr_clk2,
                      s_ready, busy, underrun};
        end
    endtask

    task automatic wait_start(input string tag, input int bound, output int st);
        st = 0;
        while (ddr_ctl1 !== 1'b1 && st < bound) begin
            step();
            st++;
        end
        chk(tag, 32'(ddr_ctl1), 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        clk100[0] = 2'b11; clk100[1] = 2'b11; clk100[2] = 2'b10;
        clk100[3] = 2'b00; clk100[4] = 2'b00;
        rst = 1'b1; speed = 2'b10;
        s_valid = 1'b0; s_data = 8'h00; s_last = 1'b0; s_err = 1'b0;
        q_len = 0; q_idx = 0; q_drop = -1;
        idle(3);
        chk("rst_data", {ddr_d1, ddr_d2, ddr_ctl1, ddr_ctl2}, 0);
        chk("rst_misc", {ddr_clk1, ddr_clk2, s_ready, busy, underrun}, 0);
        rst = 1'b0;
        idle(3);
        chk("idle_clk1000", {ddr_clk1, ddr_clk2}, 2'b10);
        chk("idle_busy", busy, 0);

        // 1000 Mb/s frame A1 B2 C3
        q_data[0] = 8'hA1; q_data[1] = 8'hB2; q_data[2] = 8'hC3;
        q_err[0] = 0; q_err[1] = 0; q_err[2] = 0;
        start_frame(3);
        wait_start("t1_start", 4, steps);
        chk("t1_latency", steps, 1);
        cap(24);
        for (int i = 0; i < 7; i++) chk("t1_pre", pat(i), pk(4'h5, 4'h5, 1, 1));
        chk("t1_sfd", pat(7), pk(4'h5, 4'hD, 1, 1));
        chk("t1_b0", pat(8), pk(4'h1, 4'hA, 1, 1));
        chk("t1_b1", pat(9), pk(4'h2, 4'hB, 1, 1));
        chk("t1_b2", pat(10), pk(4'h3, 4'hC, 1, 1));
        chk("t1_clk", {rec[8].k1, rec[8].k2}, 2'b10);
        for (int i = 11; i < 23; i++) chk("t1_ifg", pat(i), 0);
        chk("t1_ifg_busy", rec[22].bsy, 1);
        chk("t1_idle", rec[23].bsy, 0);
        cnt = 0;
        for (int i = 0; i < 24; i++) cnt += int'(rec[i].rdy);
        chk("t1_ready_cnt", cnt, 3);
        chk("t1_ready_sfd", rec[7].rdy, 1);

        // 100 Mb/s frame 3C
        speed = 2'b01;
        idle(3);
        q_data[0] = 8'h3C; q_err[0] = 0;
        start_frame(1);
        wait_start("t2_start", 40, steps);
        cap(212);
        for (int i = 0; i < 20; i++) chk("t2_clk", {rec[i].k1, rec[i].k2}, clk100[i % 5]);
        for (int i = 0; i < 90; i++) begin
            n = (i < 75) ? 4'h5 : (i < 80) ? 4'hD : (i < 85) ? 4'hC : 4'h3;
            chk("t2_nib", pat(i), pk(n, n, 1, 1));
        end
        cnt = 0;
        for (int i = 90; i < 210; i++) cnt += int'(rec[i].c1 | rec[i].c2);
        chk("t2_ifg_ctl", cnt, 0);
        chk("t2_ifg_busy", rec[209].bsy, 1);
        chk("t2_idle", rec[210].bsy, 0);
        chk("t2_ready_sfd", rec[79].rdy, 1);
        cnt = 0;
        for (int i = 0; i < 212; i++) cnt += int'(rec[i].rdy);
        chk("t2_ready_cnt", cnt, 1);

        // 10 Mb/s idle TXC
        speed = 2'b00;
        cap(130);
        edge_at = -1;
        for (int i = 1; i < 70; i++)
            if (edge_at < 0 && rec[i].k1 && !rec[i-1].k1) edge_at = i;
        chk("t3_edge_found", 32'(edge_at >= 0), 1);
        if (edge_at >= 0) begin
            for (int c = 0; c <= 50; c++) begin
                chk("t3_clk1", rec[edge_at + c].k1, 32'((c % 50) < 25));
                chk("t3_clk2", rec[edge_at + c].k2, 32'((c % 50) < 25));
            end
        end
        chk("t3_ctl", {rec[100].c1, rec[100].c2}, 0);

        // 1000 Mb/s underrun after 2 of 4 bytes
        speed = 2'b10;
        idle(3);
        q_data[0] = 8'h11; q_data[1] = 8'h22; q_data[2] = 8'h33; q_data[3] = 8'h44;
        for (int i = 0; i < 4; i++) q_err[i] = 0;
        q_drop = 2;
        start_frame(4);
        wait_start("t4_start", 4, steps);
        cap(24);
        chk("t4_b0", pat(8), pk(4'h1, 4'h1, 1, 1));
        chk("t4_b1", pat(9), pk(4'h2, 4'h2, 1, 1));
        chk("t4_err_slot", pat(10), pk(4'h0, 4'h0, 1, 0));
        chk("t4_ur_pulse", rec[10].ur, 1);
        cnt = 0;
        for (int i = 0; i < 24; i++) cnt += int'(rec[i].ur);
        chk("t4_ur_cnt", cnt, 1);
        for (int i = 11; i < 23; i++) chk("t4_ifg", pat(i), 0);
        chk("t4_ifg_busy", rec[22].bsy, 1);
        chk("t4_idle", rec[23].bsy, 0);
        q_drop = -1;

        // TX_ER on bytes 2 and last, speed change to 100 mid-frame ignored
        q_data[0] = 8'hA0; q_data[1] = 8'hB1; q_data[2] = 8'hC2;
        q_err[0] = 0; q_err[1] = 1; q_err[2] = 1;
        start_frame(3);
        wait_start("t5_start", 4, steps);
        speed = 2'b01;
        cap(24);
        chk("t5_sfd", pat(7), pk(4'h5, 4'hD, 1, 1));
        chk("t5_b0", pat(8), pk(4'h0, 4'hA, 1, 1));
        chk("t5_b1_err", pat(9), pk(4'h1, 4'hB, 1, 0));
        chk("t5_last_err", pat(10), pk(4'h2, 4'hC, 1, 0));
        for (int i = 11; i < 23; i++) chk("t5_ifg", pat(i), 0);
        chk("t5_ifg_clk", {rec[22].k1, rec[22].k2}, 2'b10);
        chk("t5_idle", rec[23].bsy, 0);
        q_data[0] = 8'h5A; q_err[0] = 0;
        start_frame(1);
        wait_start("t5_next_start", 40, steps);
        cap(10);
        for (int i = 0; i < 10; i++) begin
            chk("t5_next_clk", {rec[i].k1, rec[i].k2}, clk100[i % 5]);
            chk("t5_next_pre", pat(i), pk(4'h5, 4'h5, 1, 1));
        end
        steps = 0;
        while (busy !== 1'b0 && steps < 400) begin
            step();
            steps++;
        end
        chk("t5_next_done", busy, 0);

        // reset during DATA, then a fresh frame
        speed = 2'b10;
        idle(3);
        q_data[0] = 8'h11; q_data[1] = 8'h22; q_data[2] = 8'h33; q_data[3] = 8'h44;
        for (int i = 0; i < 4; i++) q_err[i] = 0;
        start_frame(4);
        wait_start("t6_start", 4, steps);
        cap(10);
        chk("t6_pre_rst", pat(9), pk(4'h2, 4'h2, 1, 1));
        rst = 1'b1;
        q_len = 0;
        load();
        step();
        chk("t6_rst_data", {ddr_d1, ddr_d2, ddr_ctl1, ddr_ctl2}, 0);
        chk("t6_rst_misc", {ddr_clk1, ddr_clk2, s_ready, busy, underrun}, 0);
        rst = 1'b0;
        step();
        chk("t6_busy", busy, 0);
        chk("t6_ctl", {ddr_ctl1, ddr_ctl2}, 0);
        q_data[0] = 8'h66; q_data[1] = 8'h77;
        q_err[0] = 0; q_err[1] = 0;
        start_frame(2);
        wait_start("t6_restart", 4, steps);
        chk("t6_latency", steps, 1);
        cap(12);
        for (int i = 0; i < 7; i++) chk("t6_pre", pat(i), pk(4'h5, 4'h5, 1, 1));
        chk("t6_sfd", pat(7), pk(4'h5, 4'hD, 1, 1));
        chk("t6_b0", pat(8), pk(4'h6, 4'h6, 1, 1));
        chk("t6_b1", pat(9), pk(4'h7, 4'h7, 1, 1));
        chk("t6_ifg", pat(10), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
